key_seq_ctrl: RTL and testbench



---
 rtl/key_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_key_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_seq_ctrl.sv
// Key-device access sequencer: requests the bus, issues NUM_UNLOCK unlock strobes,
// then reads NUM_BITS serial response bits LSB-first into result.
module key_seq_ctrl #(
   parameter int NUM_UNLOCK = 8,
   parameter int NUM_BITS   = 16,
   parameter int STROBE_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] unlock_code,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [13:0] ba,
   output logic        br_w,
   output logic        sser_n,
   input  logic        sdrd,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] result
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_UNLOCK, S_GAP_U, S_READ, S_GAP_R, S_FIN
   } state_t;

   localparam logic [3:0] UNL_LAST  = 4'(NUM_UNLOCK);
   localparam logic [4:0] BITS_LAST = 5'(NUM_BITS);
   localparam logic [2:0] CYC_LAST  = 3'(STROBE_CYC - 1);

   state_t      state;
   logic [31:0] code;
   logic [3:0]  unl_cnt;
   logic [4:0]  bit_cnt;
   logic [2:0]  cyc_cnt;
   logic [3:0]  unl_inc;
   logic [4:0]  bit_inc;
   logic [31:0] code_shift;

   // Counters stop at their terminal values instead of wrapping.
   assign unl_inc    = (unl_cnt < UNL_LAST)  ? unl_cnt + 4'd1 : unl_cnt;
   assign bit_inc    = (bit_cnt < BITS_LAST) ? bit_cnt + 5'd1 : bit_cnt;
   assign code_shift = code >> {unl_inc[2:0], 2'b00};

   function automatic logic [13:0] access_ba(input logic [3:0] nib);
      return {2'b01, 4'b0000, nib, 4'b0000};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         code    <= '0;
         unl_cnt <= '0;
         bit_cnt <= '0;
         cyc_cnt <= '0;
         bus_req <= 1'b0;
         sser_n  <= 1'b1;
         br_w    <= 1'b1;
         ba      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         result  <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         br_w <= 1'b1;
         if (state != S_IDLE && abort) begin
            // Abort wins over every other transition, including the final sample.
            state   <= S_IDLE;
            sser_n  <= 1'b1;
            ba      <= '0;
            bus_req <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
            result  <= '0;
            cyc_cnt <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !abort) begin
                     code    <= unlock_code;
                     unl_cnt <= '0;
                     bit_cnt <= '0;
                     cyc_cnt <= '0;
                     result  <= '0;
                     bus_req <= 1'b1;
                     busy    <= 1'b1;
                     state   <= S_REQ;
                  end
               end
               S_REQ: begin
                  if (bus_gnt) begin
                     state   <= S_UNLOCK;
                     sser_n  <= 1'b0;
                     ba      <= access_ba(code[3:0]);
                     cyc_cnt <= '0;
                  end
               end
               S_UNLOCK: begin
                  if (cyc_cnt == CYC_LAST) begin
                     state  <= S_GAP_U;
                     sser_n <= 1'b1;
                     ba     <= '0;
                  end else begin
                     cyc_cnt <= cyc_cnt + 3'd1;
                  end
               end
               S_GAP_U: begin
                  unl_cnt <= unl_inc;
                  cyc_cnt <= '0;
                  sser_n  <= 1'b0;
                  if (unl_inc == UNL_LAST) begin
                     state <= S_READ;
                     ba    <= access_ba(4'h0);
                  end else begin
                     state <= S_UNLOCK;
                     ba    <= access_ba(code_shift[3:0]);
                  end
               end
               S_READ: begin
                  if (cyc_cnt == CYC_LAST) begin
                     result[bit_cnt[3:0]] <= sdrd;
                     state  <= S_GAP_R;
                     sser_n <= 1'b1;
                     ba     <= '0;
                  end else begin
                     cyc_cnt <= cyc_cnt + 3'd1;
                  end
               end
               S_GAP_R: begin
                  bit_cnt <= bit_inc;
                  cyc_cnt <= '0;
                  if (bit_inc == BITS_LAST) begin
                     state <= S_FIN;
                     done  <= 1'b1;
                  end else begin
                     state  <= S_READ;
                     sser_n <= 1'b0;
                     ba     <= access_ba(4'h0);
                  end
               end
               S_FIN: begin
                  state   <= S_IDLE;
                  bus_req <= 1'b0;
                  busy    <= 1'b0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_seq_ctrl.sv
// Directed bench for key_seq_ctrl: default-parameter instance plus a minimal
// 1-unlock/1-bit/1-cycle instance, with address and result scoreboards.
module tb_key_seq_ctrl;

   localparam int STROBE_CYC = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort, bus_gnt, sdrd;
   logic [31:0] unlock_code;
   logic        bus_req, br_w, sser_n, busy, done, err;
   logic [13:0] ba;
   logic [15:0] result;

   logic        s_start, s_abort, s_bus_gnt, s_sdrd;
   logic [31:0] s_unlock_code;
   logic        s_bus_req, s_br_w, s_sser_n, s_busy, s_done, s_err;
   logic [13:0] s_ba;
   logic [15:0] s_result;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [13:0] exp_q[$];
   logic [15:0] res_q[$];
   logic [13:0] s_exp_q[$];

   int          strobe_cnt = 0;
   int          read_idx   = 0;
   int          low_len    = 0;
   int          done_cnt   = 0;
   int          err_cnt    = 0;
   logic        prev_sser  = 1'b1;
   logic [15:0] sdrd_pat   = '0;

   always #5 clk = ~clk;

   key_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .unlock_code(unlock_code), .bus_req(bus_req), .bus_gnt(bus_gnt),
      .ba(ba), .br_w(br_w), .sser_n(sser_n), .sdrd(sdrd), .busy(busy),
      .done(done), .err(err), .result(result)
   );

   key_seq_ctrl #(.NUM_UNLOCK(1), .NUM_BITS(1), .STROBE_CYC(1)) u_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
      .unlock_code(s_unlock_code), .bus_req(s_bus_req), .bus_gnt(s_bus_gnt),
      .ba(s_ba), .br_w(s_br_w), .sser_n(s_sser_n), .sdrd(s_sdrd), .busy(s_busy),
      .done(s_done), .err(s_err), .result(s_result)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pushes the expected strobe addresses (first n_push of them) and optionally the result.
   task automatic do_start(input logic [31:0] code, input logic [15:0] pat,
                           input int n_push, input bit push_res);
      logic [3:0] nib;
      unlock_code = code;
      sdrd_pat    = pat;
      strobe_cnt  = 0;
      read_idx    = 0;
      for (int k = 0; k < 24; k++) begin
         if (k < n_push) begin
            if (k < 8) begin
               nib = code[4*k +: 4];
               exp_q.push_back({2'b01, 4'b0000, nib, 4'b0000});
            end else begin
               exp_q.push_back(14'h1000);
            end
         end
      end
      if (push_res) res_q.push_back(pat);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_strobes(input int n, input int budget);
      int b;
      b = budget;
      while (strobe_cnt < n && b > 0) begin
         tick();
         b--;
      end
      check("wait_strobes", 32'(strobe_cnt >= n), 1);
   endtask

   task automatic wait_done(input int target, input int budget);
      int b;
      b = budget;
      while (done_cnt < target && b > 0) begin
         tick();
         b--;
      end
      check("wait_done", 32'(done_cnt >= target), 1);
   endtask

   // Monitor: pops expected addresses at each strobe start and feeds the sdrd pattern.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_sser = 1'b1;
         low_len   = 0;
      end else begin
         check("br_w", br_w, 1);
         check("done_err_excl", done & err, 0);
         if (sser_n == 1'b0) begin
            if (prev_sser) begin
               check("strobe_pending", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) check("strobe_ba", ba, exp_q.pop_front());
               if (strobe_cnt >= 8) begin
                  sdrd = sdrd_pat[read_idx[3:0]];
                  read_idx++;
               end
               strobe_cnt++;
               low_len = 0;
            end
            low_len++;
         end else begin
            if (!prev_sser && !err) check("strobe_len", low_len, STROBE_CYC);
            check("idle_ba", ba, 0);
         end
         if (done) begin
            done_cnt++;
            check("result_pending", 32'(res_q.size() != 0), 1);
            if (res_q.size() != 0) check("result", result, res_q.pop_front());
         end
         if (err) err_cnt++;
         prev_sser = sser_n;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  s_exp_ser;
      logic        s_prev;
      int          d0, e0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; bus_gnt = 1'b1; sdrd = 1'b0;
      unlock_code = '0;
      s_start = 1'b0; s_abort = 1'b0; s_bus_gnt = 1'b1; s_sdrd = 1'b1;
      s_unlock_code = 32'h0000_000A;
      repeat (3) tick();

      check("rst_bus_req", bus_req, 0);
      check("rst_sser_n", sser_n, 1);
      check("rst_br_w", br_w, 1);
      check("rst_ba", ba, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_result", result, 0);

      // Full default sequence, start on the first edge after reset release.
      rst_n = 1'b1;
      do_start(32'h7654_3210, 16'h5555, 24, 1'b1);
      check("start_busy", busy, 1);
      check("start_bus_req", bus_req, 1);
      wait_done(1, 200);
      check("seq1_strobes", strobe_cnt, 24);
      tick();
      check("fin_bus_req", bus_req, 0);
      check("fin_busy", busy, 0);
      check("result_hold", result, 16'h5555);
      check("seq1_drained", exp_q.size(), 0);

      // Grant withheld for 10 clocks; a second start mid-sequence must be ignored.
      bus_gnt = 1'b0;
      do_start($urandom, 16'($urandom), 24, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("nogrant_bus_req", bus_req, 1);
         check("nogrant_sser_n", sser_n, 1);
      end
      bus_gnt = 1'b1;
      tick();
      check("grant_strobe", sser_n, 0);
      wait_strobes(5, 100);
      unlock_code = 32'hFFFF_FFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(2, 200);
      check("seq2_strobes", strobe_cnt, 24);
      check("seq2_drained", exp_q.size(), 0);
      repeat (2) tick();

      // Abort in the third read access.
      d0 = done_cnt;
      e0 = err_cnt;
      do_start($urandom, 16'hFFFF, 11, 1'b0);
      wait_strobes(11, 100);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_sser_n", sser_n, 1);
      check("abort_bus_req", bus_req, 0);
      check("abort_err", err, 1);
      check("abort_result", result, 0);
      check("abort_busy", busy, 0);
      tick();
      check("abort_err_pulse", err, 0);
      repeat (5) tick();
      check("abort_err_cnt", err_cnt - e0, 1);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_strobes", strobe_cnt, 11);

      // Abort while idle does nothing, and start with abort is ignored.
      abort = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_err", err, 0);

      // Reset mid-unlock, then a clean full sequence.
      d0 = done_cnt;
      e0 = err_cnt;
      do_start(32'h89AB_CDEF, 16'h0F0F, 24, 1'b1);
      wait_strobes(3, 100);
      check("pre_rst_sser_n", sser_n, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sser_n", sser_n, 1);
      check("arst_bus_req", bus_req, 0);
      check("arst_ba", ba, 0);
      check("arst_busy", busy, 0);
      check("arst_result", result, 0);
      exp_q.delete();
      res_q.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check("arst_no_done", done_cnt - d0, 0);
      check("arst_no_err", err_cnt - e0, 0);
      do_start(32'h1357_9BDF, 16'($urandom), 24, 1'b1);
      wait_done(d0 + 1, 200);
      check("seq4_strobes", strobe_cnt, 24);
      check("seq4_drained", exp_q.size(), 0);
      repeat (2) tick();

      // Minimal configuration: two single-clock strobes with one idle clock between.
      s_exp_q.push_back(14'h10A0);
      s_exp_q.push_back(14'h1000);
      s_exp_ser = 5'b11010;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      check("small_req_sser_n", s_sser_n, 1);
      check("small_req_bus_req", s_bus_req, 1);
      s_prev = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("small_sser_n", s_sser_n, s_exp_ser[i]);
         if (s_sser_n == 1'b0 && s_prev) begin
            check("small_pending", 32'(s_exp_q.size() != 0), 1);
            if (s_exp_q.size() != 0) check("small_ba", s_ba, s_exp_q.pop_front());
         end
         s_prev = s_sser_n;
      end
      check("small_done", s_done, 1);
      check("small_result", s_result, 16'h0001);
      tick();
      check("small_done_pulse", s_done, 0);
      check("small_bus_req_drop", s_bus_req, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
